// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to two finished results per cycle in
// round-robin order and broadcasts them on the two registered CDB buses.
module cdb_arbiter #(
    parameter int unsigned      NUM_REQ     = 4,
    parameter int unsigned      DATA_W      = 32,
    parameter int unsigned      ROB_W       = 6,
    parameter logic [ROB_W-1:0] INVALID_TAG = ROB_W'(16)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] reqData,
    input  logic [NUM_REQ*ROB_W-1:0]  reqRobNum,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      cdbIscast,
    output logic [DATA_W-1:0]         cdbData,
    output logic [ROB_W-1:0]          cdbRobNum,
    output logic                      cdbIscast2,
    output logic [DATA_W-1:0]         cdbData2,
    output logic [ROB_W-1:0]          cdbRobNum2,
    output logic [15:0]               castCount
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 16;

    logic [PTR_W-1:0]   ptr;
    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic [ROB_W-1:0]   tag_arr  [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic               a_found;
    logic               b_found;
    logic [PTR_W-1:0]   a_idx;
    logic [PTR_W-1:0]   b_idx;

    // Unpack flat producer buses; an INVALID_TAG request is never eligible
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = reqData[i*DATA_W +: DATA_W];
        assign tag_arr[i]  = reqRobNum[i*ROB_W +: ROB_W];
        assign eligible[i] = req[i] && (tag_arr[i] != INVALID_TAG);
    end

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
        if (32'(i) == NUM_REQ - 1) return '0;
        return i + PTR_W'(1);
    endfunction

    // First two eligible requesters in search order starting at ptr
    always_comb begin
        int unsigned      s;
        logic [PTR_W-1:0] idx;
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        s       = 0;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            s = 32'(ptr) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            idx = PTR_W'(s);
            if (eligible[idx]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = idx;
                end else if (!b_found) begin
                    b_found = 1'b1;
                    b_idx   = idx;
                end
            end
        end
    end

    // Grant is suppressed during reset so held requests survive it
    always_comb begin
        grant = '0;
        if (!reset) begin
            if (a_found) grant[a_idx] = 1'b1;
            if (b_found) grant[b_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr        <= '0;
            castCount  <= '0;
            cdbIscast  <= 1'b0;
            cdbData    <= '0;
            cdbRobNum  <= INVALID_TAG;
            cdbIscast2 <= 1'b0;
            cdbData2   <= '0;
            cdbRobNum2 <= INVALID_TAG;
        end else begin
            cdbIscast  <= a_found;
            cdbData    <= a_found ? data_arr[a_idx] : '0;
            cdbRobNum  <= a_found ? tag_arr[a_idx] : INVALID_TAG;
            cdbIscast2 <= b_found;
            cdbData2   <= b_found ? data_arr[b_idx] : '0;
            cdbRobNum2 <= b_found ? tag_arr[b_idx] : INVALID_TAG;
            if (b_found)      ptr <= wrap_inc(b_idx);
            else if (a_found) ptr <= wrap_inc(a_idx);
            castCount <= castCount + CNT_W'(a_found) + CNT_W'(b_found);
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: reference model feeds a scoreboard
// queue of expected bus states, compared one cycle after each grant.
module tb_cdb_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 6;
    localparam logic [RW-1:0] INV = 6'd16;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] reqData;
    logic [N*RW-1:0] reqRobNum;
    logic [N-1:0]    grant;
    logic            cdbIscast, cdbIscast2;
    logic [DW-1:0]   cdbData, cdbData2;
    logic [RW-1:0]   cdbRobNum, cdbRobNum2;
    logic [15:0]     castCount;

    logic [DW-1:0] d_in [N];
    logic [RW-1:0] t_in [N];

    typedef struct {
        logic          v1;
        logic [DW-1:0] d1;
        logic [RW-1:0] t1;
        logic          v2;
        logic [DW-1:0] d2;
        logic [RW-1:0] t2;
        logic [15:0]   cnt;
        logic [1:0]    ptr;
    } exp_t;

    exp_t        sb [$];
    int          m_ptr;
    logic [15:0] m_cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    cdb_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .reqData    (reqData),
        .reqRobNum  (reqRobNum),
        .grant      (grant),
        .cdbIscast  (cdbIscast),
        .cdbData    (cdbData),
        .cdbRobNum  (cdbRobNum),
        .cdbIscast2 (cdbIscast2),
        .cdbData2   (cdbData2),
        .cdbRobNum2 (cdbRobNum2),
        .castCount  (castCount)
    );

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign reqData[i*DW +: DW]   = d_in[i];
        assign reqRobNum[i*RW +: RW] = t_in[i];
    end

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle from just after a falling edge, check grant, then
    // check the bus state produced by the following rising edge.
    task automatic cycle(input logic rst, input logic [N-1:0] r, output logic [N-1:0] g);
        int          a;
        int          b;
        exp_t        e;
        exp_t        o;
        logic [N-1:0] eg;
        reset = rst;
        req   = r;
        #1;
        a = -1;
        b = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (r[i] && t_in[i] != INV) begin
                    if (a < 0) a = i;
                    else if (b < 0) b = i;
                end
            end
        end
        eg = '0;
        if (a >= 0) eg[a] = 1'b1;
        if (b >= 0) eg[b] = 1'b1;
        g = grant;
        check("grant", 64'(grant), 64'(eg));

        e.v1 = 1'b0; e.d1 = '0; e.t1 = INV;
        e.v2 = 1'b0; e.d2 = '0; e.t2 = INV;
        if (a >= 0) begin e.v1 = 1'b1; e.d1 = d_in[a]; e.t1 = t_in[a]; end
        if (b >= 0) begin e.v2 = 1'b1; e.d2 = d_in[b]; e.t2 = t_in[b]; end
        if (rst) begin
            m_ptr = 0;
            m_cnt = '0;
        end else begin
            if (b >= 0)      m_ptr = (b + 1) % N;
            else if (a >= 0) m_ptr = (a + 1) % N;
            if (a >= 0) m_cnt++;
            if (b >= 0) m_cnt++;
        end
        e.cnt = m_cnt;
        e.ptr = 2'(m_ptr);
        sb.push_back(e);

        @(posedge clock);
        @(negedge clock);
        if (sb.size() == 0) begin
            check("sb_empty", 64'(1), 64'(0));
        end else begin
            o = sb.pop_front();
            check("cdbIscast",  64'(cdbIscast),  64'(o.v1));
            check("cdbData",    64'(cdbData),    64'(o.d1));
            check("cdbRobNum",  64'(cdbRobNum),  64'(o.t1));
            check("cdbIscast2", 64'(cdbIscast2), 64'(o.v2));
            check("cdbData2",   64'(cdbData2),   64'(o.d2));
            check("cdbRobNum2", 64'(cdbRobNum2), 64'(o.t2));
            check("castCount",  64'(castCount),  64'(o.cnt));
            check("ptr",        64'(dut.ptr),    64'(o.ptr));
        end
    endtask

    task automatic set_tags_1234();
        for (int i = 0; i < N; i++) begin
            t_in[i] = 6'(i + 1);
            d_in[i] = 32'hA000_0000 + 32'(i);
        end
    endtask

    initial begin
        logic [N-1:0] g;
        int           w3;
        reset = 1'b1;
        req   = '0;
        m_ptr = 0;
        m_cnt = '0;
        for (int i = 0; i < N; i++) begin
            d_in[i] = '0;
            t_in[i] = INV;
        end
        @(negedge clock);

        // Reset state
        cycle(1'b1, 4'b0000, g);
        cycle(1'b1, 4'b0000, g);

        // Single request from the load unit
        t_in[2] = 6'd5;
        d_in[2] = 32'hDEAD_BEEF;
        cycle(1'b0, 4'b0100, g);
        check("single_grant", 64'(g), 64'(4'b0100));
        check("single_tag", 64'(cdbRobNum), 64'(6'd5));
        check("single_ptr", 64'(dut.ptr), 64'(3));

        // Wrap-around from ptr=3
        t_in[0] = 6'd7;  d_in[0] = 32'h0000_0707;
        t_in[3] = 6'd9;  d_in[3] = 32'h0000_0909;
        cycle(1'b0, 4'b1001, g);
        check("wrap_grant", 64'(g), 64'(4'b1001));
        check("wrap_bus1", 64'(cdbRobNum), 64'(6'd9));
        check("wrap_bus2", 64'(cdbRobNum2), 64'(6'd7));
        check("wrap_ptr", 64'(dut.ptr), 64'(1));

        // Invalid tag is never granted and leaves ptr alone
        t_in[0] = INV;
        cycle(1'b0, 4'b0001, g);
        check("inv_grant", 64'(g), 64'(0));
        check("inv_ptr", 64'(dut.ptr), 64'(1));

        // Dual grant and round-robin from ptr=0
        cycle(1'b1, 4'b0000, g);
        set_tags_1234();
        cycle(1'b0, 4'b1111, g);
        check("dual_grant1", 64'(g), 64'(4'b0011));
        cycle(1'b0, 4'b1111, g);
        check("dual_grant2", 64'(g), 64'(4'b1100));
        check("dual_cnt", 64'(castCount), 64'(4));

        // Starvation: producer 3 must win within 2 cycles
        w3 = 0;
        for (int c = 0; c < 24; c++) begin
            cycle(1'b0, 4'b1011, g);
            if (g[3]) w3 = 0;
            else w3++;
            check("starve_p3", 64'(w3 >= 2), 64'(0));
            if (g[0]) begin t_in[0] = 6'($urandom_range(0, 15));  d_in[0] = $urandom; end
            if (g[1]) begin t_in[1] = 6'($urandom_range(17, 40)); d_in[1] = $urandom; end
            if (g[3]) begin t_in[3] = 6'($urandom_range(41, 63)); d_in[3] = $urandom; end
        end

        // Reset mid-stream with all producers holding
        set_tags_1234();
        cycle(1'b0, 4'b1111, g);
        set_tags_1234();
        cycle(1'b1, 4'b1111, g);
        check("rst_grant", 64'(g), 64'(0));
        check("rst_cnt", 64'(castCount), 64'(0));
        cycle(1'b0, 4'b1111, g);
        check("post_rst_grant", 64'(g), 64'(4'b0011));

        // Random traffic including invalid tags
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < N; i++) begin
                t_in[i] = ($urandom_range(0, 5) == 0) ? INV : 6'($urandom_range(0, 63));
                d_in[i] = $urandom;
            end
            cycle(1'b0, 4'($urandom), g);
        end

        // castCount wrap: 32767 dual-grant cycles bring it to 16'hFFFE
        cycle(1'b1, 4'b0000, g);
        set_tags_1234();
        reset = 1'b0;
        req   = 4'b1111;
        repeat (32767) @(negedge clock);
        m_cnt = 16'(32'(m_cnt) + 2 * 32767);
        m_ptr = (m_ptr + 2 * 32767) % N;
        check("cnt_pre_wrap", 64'(castCount), 64'(16'hFFFE));
        cycle(1'b0, 4'b1111, g);
        check("cnt_wrap", 64'(castCount), 64'(0));
        cycle(1'b0, 4'b1111, g);
        check("cnt_after_wrap", 64'(castCount), 64'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
